scv_rominit_sink: RTL

Receiving end of the ROM-initialisation byte stream driven into `scv` by the loader (`ROMINIT_SEL_*`, `ROMINIT_ADDR`, `ROMINIT_DATA`, `ROMINIT_VALID`). It validates the stream, routes each byte as a registered write strobe to the boot (uPD7801), character (EpochTV), APU (uPD1771) or cart memory, and records per-image length and completion. The latched cart length feeds `MAPPER_AUTO` selection. Sits inside `scv`, between the top-level ROMINIT ports and the ROM/RAM instances.

---
 rtl/scv_rominit_sink.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/scv_rominit_sink.sv
// scv_rominit_sink: receiving end of the ROM-initialisation byte stream.
// Validates the stream (one target at a time, strictly sequential addresses,
// no overflow past the target's size), turns each accepted byte into a
// registered one-cycle write strobe, and records per-image completion plus
// the length of the last committed cart image.
// Optional build macro: SCV_ROMINIT_CHECKSUM_EN adds CKSUM_BOOT/CHR/APU/CART,
// the mod-2^16 sum of the accepted bytes of the last committed image per target.
module scv_rominit_sink #(
    parameter int unsigned BOOT_AW = 12,
    parameter int unsigned CHR_AW  = 10,
    parameter int unsigned APU_AW  = 10,
    parameter int unsigned CART_AW = 17
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        ROMINIT_SEL_BOOT,
    input  logic        ROMINIT_SEL_CHR,
    input  logic        ROMINIT_SEL_APU,
    input  logic        ROMINIT_SEL_CART,
    input  logic [24:0] ROMINIT_ADDR,
    input  logic [7:0]  ROMINIT_DATA,
    input  logic        ROMINIT_VALID,
    output logic [24:0] WR_ADDR,
    output logic [7:0]  WR_DATA,
    output logic        WR_BOOT,
    output logic        WR_CHR,
    output logic        WR_APU,
    output logic        WR_CART,
    output logic [3:0]  LOADED,
    output logic [17:0] CART_LEN,
    output logic        ERR
`ifdef SCV_ROMINIT_CHECKSUM_EN
    ,
    output logic [15:0] CKSUM_BOOT,
    output logic [15:0] CKSUM_CHR,
    output logic [15:0] CKSUM_APU,
    output logic [15:0] CKSUM_CART
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COMMIT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  tgt_q, tgt_d;
    logic [17:0] cnt_q, cnt_d;
    logic [24:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [3:0]  wr_stb_q, wr_stb_d;
    logic [3:0]  loaded_q, loaded_d;
    logic [17:0] cart_len_q, cart_len_d;
    logic        err_q, err_d;

    logic [3:0]  sel;
    logic [3:0]  tgt_mask;
    logic [17:0] lim;
    logic        start;
    logic        accept;
    logic        commit;

    // Target index 0..3 matches the LOADED bit order {cart, apu, chr, boot}
    function automatic logic [1:0] sel_index(input logic [3:0] s);
        if (s[0])      return 2'd0;
        else if (s[1]) return 2'd1;
        else if (s[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign sel      = {ROMINIT_SEL_CART, ROMINIT_SEL_APU, ROMINIT_SEL_CHR, ROMINIT_SEL_BOOT};
    assign tgt_mask = 4'b0001 << tgt_q;
    assign start    = (state_q == ST_IDLE) && $onehot(sel);
    assign accept   = (state_q == ST_LOAD) && ROMINIT_VALID &&
                      (ROMINIT_ADDR == {7'd0, cnt_q}) && (cnt_q < lim);
    assign commit   = (state_q == ST_COMMIT);

    // Capacity of the latched target in bytes
    always_comb begin
        lim = '0;
        case (tgt_q)
            2'd0:    lim = 18'd1 << BOOT_AW;
            2'd1:    lim = 18'd1 << CHR_AW;
            2'd2:    lim = 18'd1 << APU_AW;
            default: lim = 18'd1 << CART_AW;
        endcase
    end

    // Next-state, write-strobe and bookkeeping logic
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        cnt_d      = cnt_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_stb_d   = '0;
        loaded_d   = loaded_q;
        cart_len_d = cart_len_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    tgt_d   = sel_index(sel);
                    cnt_d   = '0;
                end else if (sel != '0) begin
                    err_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wr_stb_d[tgt_q] = 1'b1;
                    wr_addr_d       = ROMINIT_ADDR;
                    wr_data_d       = ROMINIT_DATA;
                    cnt_d           = cnt_q + 18'd1;
                end else if (ROMINIT_VALID) begin
                    err_d = 1'b1;
                end
                // Latched SEL falling wins over any other SEL in the same cycle
                if (!sel[tgt_q]) begin
                    state_d = ST_COMMIT;
                end else if ((sel & ~tgt_mask) != '0) begin
                    err_d = 1'b1;
                end
            end
            ST_COMMIT: begin
                loaded_d[tgt_q] = 1'b1;
                if (tgt_q == 2'd3) begin
                    cart_len_d = cnt_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q    <= ST_IDLE;
            tgt_q      <= '0;
            cnt_q      <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_stb_q   <= '0;
            loaded_q   <= '0;
            cart_len_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            cnt_q      <= cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_stb_q   <= wr_stb_d;
            loaded_q   <= loaded_d;
            cart_len_q <= cart_len_d;
            err_q      <= err_d;
        end
    end

    assign WR_ADDR  = wr_addr_q;
    assign WR_DATA  = wr_data_q;
    assign WR_BOOT  = wr_stb_q[0];
    assign WR_CHR   = wr_stb_q[1];
    assign WR_APU   = wr_stb_q[2];
    assign WR_CART  = wr_stb_q[3];
    assign LOADED   = loaded_q;
    assign CART_LEN = cart_len_q;
    assign ERR      = err_q;

`ifdef SCV_ROMINIT_CHECKSUM_EN
    logic [15:0] acc_q, acc_d;
    logic [15:0] cksum_q [4];
    logic [15:0] cksum_d [4];

    // Running sum of accepted bytes, published to the target's slot on commit
    always_comb begin
        acc_d   = acc_q;
        cksum_d = cksum_q;
        if (start) begin
            acc_d = '0;
        end else if (accept) begin
            acc_d = acc_q + {8'd0, ROMINIT_DATA};
        end
        if (commit) begin
            cksum_d[tgt_q] = acc_q;
        end
    end

    // Checksum registers
    always_ff @(posedge CLK) begin
        if (RES) begin
            acc_q   <= '0;
            cksum_q <= '{default: '0};
        end else begin
            acc_q   <= acc_d;
            cksum_q <= cksum_d;
        end
    end

    assign CKSUM_BOOT = cksum_q[0];
    assign CKSUM_CHR  = cksum_q[1];
    assign CKSUM_APU  = cksum_q[2];
    assign CKSUM_CART = cksum_q[3];
`endif

endmodule
